// File: rtl/video_in_wdma.sv
// video_in_wdma: drains the packed-pixel FIFO into ping-pong frame
// buffers as fixed-length write bursts on the bus master port.
module video_in_wdma #(
   parameter int p_WIDTH  = 640,
   parameter int p_HEIGHT = 480,
   parameter int p_BURST  = 8,
   parameter int p_LVLW   = 8
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              cfg_enable,
   input  logic [31:0]       cfg_base0,
   input  logic [31:0]       cfg_base1,
   input  logic              cfg_clr,
   input  logic              frame_start,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   input  logic [p_LVLW-1:0] fifo_level,
   input  logic [31:0]       fifo_data,
   output logic              fifo_r_e,
   output logic              mst_req,
   input  logic              mst_ack,
   output logic [31:0]       mst_addr,
   output logic              mst_wvalid,
   input  logic              mst_wready,
   output logic [31:0]       mst_wdata,
   output logic              mst_last,
   output logic              frame_done,
   output logic              cur_buf,
   output logic              ovf,
   output logic              frame_err
);

   localparam int WORDS = p_WIDTH * p_HEIGHT / 4;
   localparam int BW    = (p_BURST > 1) ? $clog2(p_BURST) : 1;

   localparam logic [16:0]       LAST_WORD = 17'(WORDS - 1);
   localparam logic [BW-1:0]     LAST_BEAT = BW'(p_BURST - 1);
   localparam logic [p_LVLW-1:0] BURST_LVL = p_LVLW'(p_BURST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_WAIT_DATA,
      S_REQ,
      S_XFER,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   base_q, base_d;
   logic [16:0]   word_cnt_q, word_cnt_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic          cur_buf_q, cur_buf_d;
   logic          ovf_q, ovf_d;
   logic          frame_err_q, frame_err_d;

   logic          beat_acc;
   logic          last_acc;
   logic          sync_ok;

   assign beat_acc = (state_q == S_XFER) && mst_wready;
   assign last_acc = beat_acc && (beat_cnt_q == LAST_BEAT);
   assign sync_ok  = (state_q == S_WAIT_FRAME) && cfg_enable
                     && frame_start;

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         word_cnt_q  <= '0;
         beat_cnt_q  <= '0;
         cur_buf_q   <= 1'b0;
         ovf_q       <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         word_cnt_q  <= word_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         cur_buf_q   <= cur_buf_d;
         ovf_q       <= ovf_d;
         frame_err_q <= frame_err_d;
      end
   end

   // a started burst runs to its last beat whatever cfg_enable does
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (cfg_enable) state_d = S_WAIT_FRAME;
         end
         S_WAIT_FRAME: begin
            if (!cfg_enable)      state_d = S_IDLE;
            else if (frame_start) state_d = S_WAIT_DATA;
         end
         S_WAIT_DATA: begin
            if (!cfg_enable)                  state_d = S_IDLE;
            else if (fifo_level >= BURST_LVL) state_d = S_REQ;
         end
         S_REQ: begin
            if (mst_ack) state_d = S_XFER;
         end
         S_XFER: begin
            if (last_acc) begin
               if (word_cnt_q == LAST_WORD) state_d = S_DONE;
               else if (cfg_enable)         state_d = S_WAIT_DATA;
               else                         state_d = S_IDLE;
            end
         end
         S_DONE: begin
            state_d = cfg_enable ? S_WAIT_FRAME : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      base_d      = base_q;
      word_cnt_d  = word_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      cur_buf_d   = cur_buf_q;
      ovf_d       = ovf_q;
      frame_err_d = frame_err_q;

      if (sync_ok) begin
         base_d     = cur_buf_q ? cfg_base1 : cfg_base0;
         word_cnt_d = '0;
         beat_cnt_d = '0;
      end

      if (beat_acc) begin
         word_cnt_d = word_cnt_q + 17'd1;
         beat_cnt_d = last_acc ? '0 : beat_cnt_q + BW'(1);
      end

      if (state_q == S_DONE) cur_buf_d = ~cur_buf_q;

      // set beats clear when both land in one cycle
      if (cfg_clr) begin
         ovf_d       = 1'b0;
         frame_err_d = 1'b0;
      end
      if (fifo_full && cfg_enable) ovf_d = 1'b1;
      if (frame_start && (state_q != S_WAIT_FRAME)) frame_err_d = 1'b1;
   end

   always_comb begin
      fifo_r_e   = 1'b0;
      mst_req    = 1'b0;
      mst_addr   = '0;
      mst_wvalid = 1'b0;
      mst_wdata  = '0;
      mst_last   = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         S_WAIT_FRAME: begin
            fifo_r_e = !fifo_empty;
         end
         S_REQ: begin
            mst_req  = 1'b1;
            mst_addr = base_q + {13'd0, word_cnt_q, 2'b00};
         end
         S_XFER: begin
            mst_wvalid = 1'b1;
            mst_wdata  = fifo_data;
            mst_last   = (beat_cnt_q == LAST_BEAT);
            fifo_r_e   = mst_wready;
         end
         S_DONE: begin
            frame_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign cur_buf   = cur_buf_q;
   assign ovf       = ovf_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_video_in_wdma.sv
// Bench for video_in_wdma: show-ahead FIFO model, frame scoreboard,
// directed frames with back-pressure, stray sync, disable and reset.
module tb_video_in_wdma;

   localparam int W     = 16;
   localparam int H     = 2;
   localparam int B     = 4;
   localparam int LW    = 8;
   localparam int TOTAL = W * H / 4;

   localparam logic [31:0] BASE0 = 32'h0000_1000;
   localparam logic [31:0] BASE1 = 32'h0000_2000;

   logic          clk = 1'b0;
   logic          nRST;
   logic          cfg_enable;
   logic [31:0]   cfg_base0;
   logic [31:0]   cfg_base1;
   logic          cfg_clr;
   logic          frame_start;
   logic          fifo_empty;
   logic          fifo_full;
   logic [LW-1:0] fifo_level;
   logic [31:0]   fifo_data;
   logic          fifo_r_e;
   logic          mst_req;
   logic          mst_ack;
   logic [31:0]   mst_addr;
   logic          mst_wvalid;
   logic          mst_wready;
   logic [31:0]   mst_wdata;
   logic          mst_last;
   logic          frame_done;
   logic          cur_buf;
   logic          ovf;
   logic          frame_err;

   video_in_wdma #(
      .p_WIDTH (W),
      .p_HEIGHT(H),
      .p_BURST (B),
      .p_LVLW  (LW)
   ) dut (
      .clk        (clk),
      .nRST       (nRST),
      .cfg_enable (cfg_enable),
      .cfg_base0  (cfg_base0),
      .cfg_base1  (cfg_base1),
      .cfg_clr    (cfg_clr),
      .frame_start(frame_start),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_level (fifo_level),
      .fifo_data  (fifo_data),
      .fifo_r_e   (fifo_r_e),
      .mst_req    (mst_req),
      .mst_ack    (mst_ack),
      .mst_addr   (mst_addr),
      .mst_wvalid (mst_wvalid),
      .mst_wready (mst_wready),
      .mst_wdata  (mst_wdata),
      .mst_last   (mst_last),
      .frame_done (frame_done),
      .cur_buf    (cur_buf),
      .ovf        (ovf),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // show-ahead FIFO: writer pushes, pop on sampled fifo_r_e
   logic [31:0] fmem [256];
   logic [7:0]  wr_ptr = '0;
   logic [7:0]  rd_ptr = '0;
   assign fifo_level = wr_ptr - rd_ptr;
   assign fifo_empty = (fifo_level == '0);
   assign fifo_data  = fmem[rd_ptr];

   // stimulus-owned frame context
   int          fid = 0;
   logic [31:0] frame_base = '0;
   logic        fs_err = 1'b0;

   // model state, owned by the compare process
   int          seen_fid = 0;
   int          words_done = 0;
   logic        active = 1'b0;
   logic        exp_buf = 1'b0;
   logic        exp_ovf = 1'b0;
   logic        exp_ferr = 1'b0;
   logic        pend_done = 1'b0;
   logic [31:0] req_addr [16];
   int          req_n = 0;
   int          last_seen = 0;
   int          done_seen = 0;
   logic        pop_now = 1'b0;

   logic        armed = 1'b0;
   logic        rst_at_edge = 1'b0;

   function automatic logic [31:0] pix(input int f, input int i);
      return 32'hC0DE_0000 | 32'(f << 8) | 32'(i);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      armed       <= 1'b1;
      rst_at_edge <= !nRST;
      if (pop_now && (fifo_level != '0)) rd_ptr <= rd_ptr + 8'd1;
   end

   always @(negedge clk) begin
      pop_now = fifo_r_e;
      if (armed) begin
         if (fid != seen_fid) begin
            seen_fid   = fid;
            words_done = 0;
            active     = 1'b1;
         end
         if (rst_at_edge) begin
            chk("rst_fifo_r_e", fifo_r_e, 0);
            chk("rst_mst_req", mst_req, 0);
            chk("rst_mst_addr", mst_addr, 0);
            chk("rst_mst_wvalid", mst_wvalid, 0);
            chk("rst_mst_wdata", mst_wdata, 0);
            chk("rst_mst_last", mst_last, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_cur_buf", cur_buf, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_frame_err", frame_err, 0);
         end else begin
            chk("cur_buf", cur_buf, exp_buf);
            chk("ovf", ovf, exp_ovf);
            chk("frame_err", frame_err, exp_ferr);
            chk("frame_done", frame_done, pend_done);
            if (mst_req) begin
               chk("req_in_frame", active, 1);
               chk("mst_addr", mst_addr,
                   frame_base + 32'(4 * words_done));
               chk("req_no_wvalid", mst_wvalid, 0);
               chk("req_no_pop", fifo_r_e, 0);
            end
            if (mst_wvalid) begin
               chk("mst_wdata", mst_wdata, pix(seen_fid, words_done));
               chk("mst_last", mst_last, (words_done % B) == B - 1);
               chk("pop_on_accept", fifo_r_e, mst_wready);
            end
         end
         if (pend_done) begin
            pend_done = 1'b0;
            exp_buf   = ~exp_buf;
            active    = 1'b0;
         end
         if (mst_req && mst_ack && req_n < 16) begin
            req_addr[req_n] = mst_addr;
            req_n++;
         end
         if (mst_wvalid && mst_wready) begin
            if (mst_last) last_seen++;
            words_done++;
            if (words_done == TOTAL) pend_done = 1'b1;
         end
         if (frame_done) done_seen++;
         if (frame_start && fs_err) exp_ferr = 1'b1;
         else if (cfg_clr)          exp_ferr = 1'b0;
         if (fifo_full && cfg_enable) exp_ovf = 1'b1;
         else if (cfg_clr)            exp_ovf = 1'b0;
         if (!nRST) begin
            exp_buf    = 1'b0;
            exp_ovf    = 1'b0;
            exp_ferr   = 1'b0;
            pend_done  = 1'b0;
            active     = 1'b0;
            words_done = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      fmem[wr_ptr] = w;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic push_frame();
      for (int i = 0; i < TOTAL; i++) push(pix(fid, i));
   endtask

   task automatic start_frame();
      fid         = fid + 1;
      frame_base  = exp_buf ? BASE1 : BASE0;
      fs_err      = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic stray_start();
      fs_err      = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      fs_err      = 1'b0;
   endtask

   task automatic clr();
      cfg_clr = 1'b1;
      tick();
      cfg_clr = 1'b0;
   endtask

   task automatic wait_beats(input int k);
      int n = 0;
      while (!(mst_wvalid && words_done == k) && n < 200) begin
         tick();
         n++;
      end
      chk("beat_wait", 32'(mst_wvalid && words_done == k), 1);
   endtask

   task automatic wait_done(input int k);
      int n = 0;
      while (done_seen <= k && n < 200) begin
         tick();
         n++;
      end
      chk("done_wait", 32'(done_seen > k), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      nRST      = 1'b0;
      cfg_base0 = BASE0;
      cfg_base1 = BASE1;
      for (int i = 0; i < 3; i++) begin
         cfg_enable  = 1'($urandom_range(0, 1));
         cfg_clr     = 1'($urandom_range(0, 1));
         frame_start = 1'($urandom_range(0, 1));
         fifo_full   = 1'($urandom_range(0, 1));
         mst_ack     = 1'($urandom_range(0, 1));
         mst_wready  = 1'($urandom_range(0, 1));
         tick();
      end
      nRST        = 1'b1;
      cfg_enable  = 1'b0;
      cfg_clr     = 1'b0;
      frame_start = 1'b0;
      fifo_full   = 1'b0;
      mst_ack     = 1'b1;
      mst_wready  = 1'b1;
      tick();

      // stale words are discarded and nothing is requested
      push(32'hDEAD_0001);
      push(32'hDEAD_0002);
      cfg_enable = 1'b1;
      repeat (8) tick();
      chk("stale_drained", fifo_level, 0);
      chk("no_req_before_sync", req_n, 0);

      // frame 1: nominal into buffer 0
      start_frame();
      push_frame();
      wait_done(0);
      tick();
      tick();
      chk("f1_req_count", req_n, 2);
      chk("f1_addr0", req_addr[0], 32'h0000_1000);
      chk("f1_addr1", req_addr[1], 32'h0000_1010);
      chk("f1_last_count", last_seen, 2);
      chk("f1_done_count", done_seen, 1);
      chk("f1_cur_buf", cur_buf, 1);
      chk("f1_fifo_empty", fifo_level, 0);

      // frame 2: stall on beat 2, stray sync in burst 2
      start_frame();
      push_frame();
      wait_beats(1);
      mst_wready = 1'b0;
      repeat (5) tick();
      chk("bp_level", fifo_level, 7);
      chk("bp_wdata", mst_wdata, 32'hC0DE_0201);
      chk("bp_no_pop", fifo_r_e, 0);
      mst_wready = 1'b1;
      wait_beats(5);
      stray_start();
      wait_done(1);
      tick();
      tick();
      chk("f2_addr0", req_addr[2], 32'h0000_2000);
      chk("f2_addr1", req_addr[3], 32'h0000_2010);
      chk("f2_frame_err", frame_err, 1);
      chk("f2_done_count", done_seen, 2);
      chk("f2_cur_buf", cur_buf, 0);
      clr();
      tick();
      chk("f2_err_cleared", frame_err, 0);

      // frame 3: disable during beat 2 abandons the frame
      start_frame();
      push_frame();
      wait_beats(1);
      cfg_enable = 1'b0;
      repeat (12) tick();
      chk("f3_req_count", req_n, 5);
      chk("f3_addr0", req_addr[4], 32'h0000_1000);
      chk("f3_last_count", last_seen, 5);
      chk("f3_no_done", done_seen, 2);
      chk("f3_cur_buf", cur_buf, 0);
      chk("f3_leftover", fifo_level, 4);
      chk("f3_no_req", mst_req, 0);
      cfg_enable = 1'b1;
      repeat (8) tick();
      chk("leftover_drained", fifo_level, 0);

      // overflow flag: set, clear, set-wins, ignored while disabled
      fifo_full = 1'b1;
      tick();
      fifo_full = 1'b0;
      repeat (3) tick();
      chk("ovf_set", ovf, 1);
      clr();
      tick();
      chk("ovf_clr", ovf, 0);
      fifo_full = 1'b1;
      cfg_clr   = 1'b1;
      tick();
      fifo_full = 1'b0;
      cfg_clr   = 1'b0;
      tick();
      chk("ovf_set_wins", ovf, 1);
      clr();
      cfg_enable = 1'b0;
      fifo_full  = 1'b1;
      tick();
      fifo_full  = 1'b0;
      cfg_enable = 1'b1;
      tick();
      chk("ovf_needs_enable", ovf, 0);
      repeat (3) tick();

      // frame 4: flags raised, then reset mid-burst
      start_frame();
      push_frame();
      fifo_full = 1'b1;
      tick();
      fifo_full = 1'b0;
      wait_beats(1);
      stray_start();
      wait_beats(2);
      chk("pre_rst_flags", {30'd0, ovf, frame_err}, 32'd3);
      nRST = 1'b0;
      tick();
      chk("midrst_wvalid", mst_wvalid, 0);
      chk("midrst_req", mst_req, 0);
      chk("midrst_pop", fifo_r_e, 0);
      chk("midrst_last", mst_last, 0);
      chk("midrst_wdata", mst_wdata, 0);
      chk("midrst_flags", {30'd0, ovf, frame_err}, 0);
      nRST = 1'b1;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
